// File: rtl/axis_window_generator_pkg.sv
// window_pkg: shared coordinate type, frame states and the frame-size legality check.
package window_pkg;
  localparam int COORD_WIDTH = 13;
  typedef logic [COORD_WIDTH-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;
  function automatic bit size_legal(coord_t w, coord_t h, int k, int max_w);
    return int'(w) >= k && int'(w) <= max_w && int'(h) >= k;
  endfunction
endpackage

// File: rtl/axis_window_generator_if.sv
// axis_window_generator_if: pixel stream in, window stream out.
interface axis_window_generator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS = 1,
  parameter int KERNEL_SIZE = 5
);
  localparam int PW = DATA_WIDTH * CHANNELS;
  logic [PW-1:0] i_data;
  logic i_data_valid, i_start_of_frame, i_end_of_line;
  logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][PW-1:0] o_window;
  logic o_data_valid, o_start_of_frame, o_end_of_line;
  modport master (
    output i_data, i_data_valid, i_start_of_frame, i_end_of_line,
    input  o_window, o_data_valid, o_start_of_frame, o_end_of_line
  );
  modport slave (
    input  i_data, i_data_valid, i_start_of_frame, i_end_of_line,
    output o_window, o_data_valid, o_start_of_frame, o_end_of_line
  );
endinterface

// File: rtl/axis_window_generator_line_buffer_ram.sv
// line_buffer_ram: one line of pixels, 1W/1R, registered read returning old data on a same-address write.
module line_buffer_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/axis_window_generator.sv
// axis_window_generator: KxK sliding window over a raster stream using circular RAM line buffers.
// Define WINDOW_EOL_CHECK_EN to check i_end_of_line alignment and honour early line ends.
module axis_window_generator
  import window_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS = 1,
  parameter int KERNEL_SIZE = 5,
  parameter int MAX_IMAGE_WIDTH = 4096
) (
  input  logic   i_clk,
  input  logic   i_aresetn,
  input  coord_t IMAGE_WIDTH,
  input  coord_t IMAGE_HEIGHT,
  axis_window_generator_if.slave s,
  output logic   o_cfg_error,
  output logic   o_eol_error
);
  localparam int K = KERNEL_SIZE;
  localparam int PW = DATA_WIDTH * CHANNELS;
  localparam int AW = (MAX_IMAGE_WIDTH > 1) ? $clog2(MAX_IMAGE_WIDTH) : 1;
  localparam coord_t KM1 = coord_t'(K - 1);
  typedef logic [PW-1:0] pixel_t;
  typedef pixel_t [0:K-1][0:K-1] window_t;
  state_t state_q, state_d;
  coord_t col_q, col_d, row_q, row_d, w_q, w_d, h_q, h_d;
  coord_t w_cur, h_cur, cur_col, cur_row;
  logic cfg_err_q, cfg_err_d, eol_err_q, eol_err_d;
  logic sof, legal, accept, last_col, early_eol, eol_bad, wrap;
  logic s1_valid_q, s1_qual_q, s1_sof_q, s1_eol_q;
  logic [AW-1:0] s1_col_q;
  pixel_t s1_pix_q;
  pixel_t rd [K-1];
  pixel_t col_pix [K];
  window_t win_q;
  logic valid_q, osof_q, oeol_q;
  // An SOF beat is (0,0) of a new frame whatever state we were in.
  assign sof = s.i_data_valid && s.i_start_of_frame;
  assign legal = size_legal(IMAGE_WIDTH, IMAGE_HEIGHT, K, MAX_IMAGE_WIDTH);
  assign w_cur = sof ? IMAGE_WIDTH : w_q;
  assign h_cur = sof ? IMAGE_HEIGHT : h_q;
  assign cur_col = sof ? '0 : col_q;
  assign cur_row = sof ? '0 : row_q;
  assign accept = sof ? legal : s.i_data_valid && state_q == RUN;
  assign last_col = cur_col == w_cur - coord_t'(1);
`ifdef WINDOW_EOL_CHECK_EN
  assign early_eol = s.i_end_of_line && !last_col;
  assign eol_bad = s.i_end_of_line != last_col;
`else
  assign early_eol = 1'b0;
  assign eol_bad = 1'b0;
`endif
  assign wrap = last_col || early_eol;
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    w_d = w_q;
    h_d = h_q;
    cfg_err_d = cfg_err_q;
    eol_err_d = eol_err_q;
    if (sof) begin
      state_d = legal ? RUN : ERROR;
      w_d = IMAGE_WIDTH;
      h_d = IMAGE_HEIGHT;
      cfg_err_d = !legal;
      eol_err_d = 1'b0;
    end
    if (accept) begin
      col_d = wrap ? '0 : cur_col + coord_t'(1);
      row_d = wrap ? cur_row + coord_t'(1) : cur_row;
      eol_err_d = eol_err_d || eol_bad;
      if (wrap && cur_row == h_cur - coord_t'(1)) state_d = IDLE;
    end
  end
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      w_q <= '0;
      h_q <= '0;
      cfg_err_q <= 1'b0;
      eol_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      w_q <= w_d;
      h_q <= h_d;
      cfg_err_q <= cfg_err_d;
      eol_err_q <= eol_err_d;
    end
  end
  // Column source: row 0 is the delayed input pixel, row j the line buffer j-1 read.
  always_comb begin
    col_pix[0] = s1_pix_q;
    for (int j = 1; j < K; j++) col_pix[j] = rd[j-1];
  end
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    line_buffer_ram #(.DEPTH(MAX_IMAGE_WIDTH), .WIDTH(PW)) u_ram (
      .clk_i(i_clk),
      .we_i(s1_valid_q),
      .waddr_i(s1_col_q),
      .wdata_i(col_pix[i]),
      .raddr_i(cur_col[AW-1:0]),
      .rdata_o(rd[i])
    );
  end
  // A new SOF kills the window still in flight from the aborted frame.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      s1_valid_q <= 1'b0;
      s1_qual_q <= 1'b0;
      s1_sof_q <= 1'b0;
      s1_eol_q <= 1'b0;
      s1_col_q <= '0;
      s1_pix_q <= '0;
      win_q <= '0;
      valid_q <= 1'b0;
      osof_q <= 1'b0;
      oeol_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_qual_q <= cur_row >= KM1 && cur_col >= KM1;
      s1_sof_q <= cur_row == KM1 && cur_col == KM1;
      s1_eol_q <= last_col;
      s1_col_q <= cur_col[AW-1:0];
      s1_pix_q <= s.i_data;
      valid_q <= s1_valid_q && s1_qual_q && !sof;
      osof_q <= s1_valid_q && s1_qual_q && s1_sof_q && !sof;
      oeol_q <= s1_valid_q && s1_qual_q && s1_eol_q && !sof;
      if (s1_valid_q)
        for (int r = 0; r < K; r++) begin
          win_q[r][0] <= col_pix[r];
          for (int c = 1; c < K; c++) win_q[r][c] <= win_q[r][c-1];
        end
    end
  end
  assign s.o_window = win_q;
  assign s.o_data_valid = valid_q;
  assign s.o_start_of_frame = osof_q;
  assign s.o_end_of_line = oeol_q;
  assign o_cfg_error = cfg_err_q;
  assign o_eol_error = eol_err_q;
endmodule
